dac_tx_sched: RTL and testbench

Burst scheduler for the dual-channel (I/Q) DAC transmit path. It arbitrates between the modem baseband stream and the DDS test-tone generator, grants one source at a time, and shapes each burst. Shaping consists of a linear ramp-up, full-scale samples, a linear ramp-down and a midscale guard gap. It sits in the clk163m84 domain directly ahead of the DAC data/clock interface logic. Its output is offset-binary I/Q plus a transmit-active flag.

---
 rtl/dac_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_dac_tx_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_tx_sched.sv
// rtl/dac_tx_sched.sv - I/Q DAC burst scheduler: modem/tone arbitration, ramp shaping, guard gap
// Samples pass sample -> scaled -> offset-binary registers; dac_on is delayed to match.
module dac_tx_sched #(
  parameter int DW         = 12,
  parameter int RAMP_SHIFT = 2,
  parameter int GUARD_LEN  = 32,
  parameter int MAX_BURST  = 4096
) (
  input  logic          clk163m84,
  input  logic          rst_n,
  input  logic          m_req,
  input  logic          m_valid,
  input  logic [DW-1:0] m_i,
  input  logic [DW-1:0] m_q,
  input  logic          m_last,
  output logic          m_ready,
  input  logic          t_req,
  input  logic [DW-1:0] t_i,
  input  logic [DW-1:0] t_q,
  output logic          t_grant,
  output logic          m_grant,
  output logic [DW-1:0] dac_i,
  output logic [DW-1:0] dac_q,
  output logic          dac_on,
  output logic          busy,
  output logic          underrun,
  output logic          trunc
);

  localparam int RAMP_LEN = 1 << RAMP_SHIFT;
  localparam int KW       = RAMP_SHIFT + 1;
  localparam int CW       = $clog2(MAX_BURST + 1);
  localparam int GW       = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_ACTIVE    = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_GUARD     = 3'd4;

  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

  logic [2:0]    state;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          last_tone;

  logic [DW-1:0] cur_i, cur_q;
  logic [KW-1:0] k_s;
  logic [DW-1:0] sc_i, sc_q;
  logic          on_p0, on_p1;

  logic          shaping, shaped, accept, take, src_end, at_max, trig, pick_m;
  logic [CW-1:0] cnt_nx;

  assign shaping = (state == S_RAMP_UP) || (state == S_ACTIVE);
  assign shaped  = shaping || (state == S_RAMP_DOWN);
  assign m_ready = m_grant & shaping;
  assign busy    = (state != S_IDLE);
  assign accept  = m_ready & m_valid;
  assign take    = shaping & (t_grant | accept);
  assign cnt_nx  = cnt + CW'(1);
  assign src_end = t_grant ? ~t_req : (~m_req | (accept & m_last));
  assign at_max  = (cnt_nx == CW'(MAX_BURST));
  assign trig    = shaping & (src_end | at_max);
  // On a tie the source that did not own the previous burst wins.
  assign pick_m  = m_req & (~t_req | last_tone);

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      last_tone <= 1'b1;
      m_grant   <= 1'b0;
      t_grant   <= 1'b0;
      underrun  <= 1'b0;
      trunc     <= 1'b0;
    end else begin
      underrun <= shaping & m_grant & ~m_valid;
      trunc    <= shaping & at_max & ~src_end;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          k   <= '0;
          if (m_req | t_req) begin
            m_grant   <= pick_m;
            t_grant   <= ~pick_m;
            last_tone <= ~pick_m;
            state     <= S_RAMP_UP;
          end
        end
        S_RAMP_UP, S_ACTIVE: begin
          cnt <= cnt_nx;
          if (trig) begin
            // Ramp-down starts one step below the current k so it mirrors the ramp-up.
            if (k == '0) begin
              state <= S_GUARD;
              gcnt  <= '0;
            end else begin
              state <= S_RAMP_DOWN;
              k     <= k - KW'(1);
            end
          end else if (state == S_RAMP_UP) begin
            k <= k + KW'(1);
            if (k == KW'(RAMP_LEN - 1)) state <= S_ACTIVE;
          end
        end
        S_RAMP_DOWN: begin
          if (k == '0) begin
            state <= S_GUARD;
            gcnt  <= '0;
          end else begin
            k <= k - KW'(1);
          end
        end
        S_GUARD: begin
          if (gcnt == GW'(GUARD_LEN - 1)) begin
            state   <= S_IDLE;
            m_grant <= 1'b0;
            t_grant <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      cur_i  <= '0;
      cur_q  <= '0;
      k_s    <= '0;
      sc_i   <= '0;
      sc_q   <= '0;
      dac_i  <= MIDSCALE;
      dac_q  <= MIDSCALE;
      on_p0  <= 1'b0;
      on_p1  <= 1'b0;
      dac_on <= 1'b0;
    end else begin
      if (take) begin
        cur_i <= t_grant ? t_i : m_i;
        cur_q <= t_grant ? t_q : m_q;
      end
      k_s <= shaped ? k : '0;
      // Low DW+KW bits of the sign-extended product are exact; the slice is the >>> RAMP_SHIFT.
      sc_i <= DW'(({{KW{cur_i[DW-1]}}, cur_i} * {{DW{1'b0}}, k_s}) >> RAMP_SHIFT);
      sc_q <= DW'(({{KW{cur_q[DW-1]}}, cur_q} * {{DW{1'b0}}, k_s}) >> RAMP_SHIFT);
      dac_i  <= {~sc_i[DW-1], sc_i[DW-2:0]};
      dac_q  <= {~sc_q[DW-1], sc_q[DW-2:0]};
      on_p0  <= shaped;
      on_p1  <= on_p0;
      dac_on <= on_p1;
    end
  end

endmodule

// File: tb/tb_dac_tx_sched.sv
// tb/tb_dac_tx_sched.sv - scoreboard bench for dac_tx_sched
// Expected DAC words are queued as stimulus is driven and popped while dac_on is high.
module tb_dac_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req, m_valid, m_last, m_ready, t_req;
  logic [11:0] m_i, m_q, t_i, t_q, dac_i, dac_q;
  logic        t_grant, m_grant, dac_on, busy, underrun, trunc;

  always #5 clk = ~clk;

  dac_tx_sched #(.DW(12), .RAMP_SHIFT(2), .GUARD_LEN(8), .MAX_BURST(16)) dut (
    .clk163m84(clk), .rst_n(rst_n),
    .m_req(m_req), .m_valid(m_valid), .m_i(m_i), .m_q(m_q), .m_last(m_last), .m_ready(m_ready),
    .t_req(t_req), .t_i(t_i), .t_q(t_q),
    .t_grant(t_grant), .m_grant(m_grant),
    .dac_i(dac_i), .dac_q(dac_q), .dac_on(dac_on),
    .busy(busy), .underrun(underrun), .trunc(trunc)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] e_mon;
  bit          mon_en = 1'b0;
  int          busy_cnt = 0, ur_cnt = 0, tr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference scaling: (s*k) >>> 2 on integers, then offset binary.
  function automatic logic [23:0] ew(input int si, input int sq, input int k);
    int vi, vq;
    vi = (si * k) >>> 2;
    vq = (sq * k) >>> 2;
    return {vi[11:0] ^ 12'h800, vq[11:0] ^ 12'h800};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (underrun === 1'b1) ur_cnt++;
    if (trunc === 1'b1) tr_cnt++;
    if (mon_en) begin
      if (dac_on === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("dac_on_without_expected", 32'(dac_on), 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("dac_iq", 32'({dac_i, dac_q}), 32'(e_mon));
        end
      end else begin
        chk("midscale", 32'({dac_i, dac_q}), 32'h800800);
      end
    end
  end

  int ks_tone[14] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0};
  int vpat[8]     = '{0, 1, 1, 0, 1, 1, 1, 1};
  int kpat[8]     = '{0, 0, 1, 2, 3, 4, 4, 4};
  int idx;

  initial begin
    rst_n = 1'b0; m_req = 0; m_valid = 0; m_last = 0; t_req = 0;
    m_i = '0; m_q = '0; t_i = '0; t_q = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: midscale, every flag low.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_out", 32'({dac_on, busy, m_grant, t_grant, m_ready, underrun, trunc, dac_i, dac_q}),
          32'({7'b0, 24'h800800}));
    end
    mon_en = 1'b1;

    // Tie after reset: modem first, burst of 2 samples ended by m_last.
    m_i = 12'd100; m_q = 12'd50; t_i = 12'd200; t_q = 12'(-300);
    m_valid = 1'b1; busy_cnt = 0;
    m_req = 1'b1; t_req = 1'b1;
    @(negedge clk);
    chk("tie_m_grant", 32'(m_grant), 32'd1);
    chk("tie_t_grant", 32'(t_grant), 32'd0);
    chk("tie_busy", 32'(busy), 32'd1);
    chk("tie_m_ready", 32'(m_ready), 32'd1);
    exp_q.push_back(ew(100, 50, 0));
    @(negedge clk);
    m_last = 1'b1;
    exp_q.push_back(ew(100, 50, 1));
    exp_q.push_back(ew(100, 50, 0));
    @(negedge clk);
    m_last = 1'b0;
    chk("tie_rd_m_ready", 32'(m_ready), 32'd0);
    wait_idle("tie_modem_idle");
    chk("tie_modem_cycles", 32'(busy_cnt), 32'd11);

    // Both still requesting: tone wins now; then t_req drops at RAMP_UP k=2.
    busy_cnt = 0;
    @(negedge clk);
    chk("alt_t_grant", 32'(t_grant), 32'd1);
    chk("alt_m_grant", 32'(m_grant), 32'd0);
    m_req = 1'b0; m_valid = 1'b0;
    exp_q.push_back(ew(200, -300, 0));
    @(negedge clk);
    exp_q.push_back(ew(200, -300, 1));
    @(negedge clk);
    t_req = 1'b0;
    exp_q.push_back(ew(200, -300, 2));
    exp_q.push_back(ew(200, -300, 1));
    exp_q.push_back(ew(200, -300, 0));
    wait_idle("tone_abort_idle");
    chk("tone_abort_cycles", 32'(busy_cnt), 32'd13);
    chk("tone_abort_drained", 32'(exp_q.size()), 32'd0);

    // Constant tone 400 / -400 held 10 cycles.
    t_i = 12'd400; t_q = 12'(-400); busy_cnt = 0;
    foreach (ks_tone[i]) exp_q.push_back(ew(400, -400, ks_tone[i]));
    t_req = 1'b1;
    repeat (10) @(negedge clk);
    t_req = 1'b0;
    wait_idle("tone_idle");
    chk("tone_cycles", 32'(busy_cnt), 32'd22);
    chk("tone_drained", 32'(exp_q.size()), 32'd0);

    // Modem: 6 samples, one valid gap, m_last on the 6th.
    m_i = 12'(-8); busy_cnt = 0; ur_cnt = 0; idx = 0;
    m_req = 1'b1; m_valid = 1'b0; m_last = 1'b0;
    for (int p = 1; p <= 7; p++) begin
      @(negedge clk);
      chk("ur_pulse", 32'(underrun), 32'(p == 4));
      chk("m_ready_on", 32'(m_ready), 32'd1);
      m_valid = (vpat[p] == 1);
      if (vpat[p] == 1) idx++;
      m_q = (vpat[p] == 1) ? 12'(10 * idx) : 12'd999;
      m_last = (idx == 6) && (vpat[p] == 1);
      exp_q.push_back(ew(-8, 10 * idx, kpat[p]));
    end
    @(negedge clk);
    chk("ur_after", 32'(underrun), 32'd0);
    chk("m_ready_rd", 32'(m_ready), 32'd0);
    m_req = 1'b0; m_valid = 1'b0; m_last = 1'b0;
    for (int k = 3; k >= 0; k--) exp_q.push_back(ew(-8, 60, k));
    wait_idle("modem_idle");
    chk("modem_cycles", 32'(busy_cnt), 32'd19);
    chk("modem_ur_count", 32'(ur_cnt), 32'd1);
    chk("modem_drained", 32'(exp_q.size()), 32'd0);

    // Full-scale tone held 30 cycles: truncated at 16 samples, re-grant only after guard.
    t_i = 12'h800; t_q = 12'd2047; busy_cnt = 0; tr_cnt = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back(ew(-2048, 2047, k));
    for (int n = 0; n < 12; n++) exp_q.push_back(ew(-2048, 2047, 4));
    for (int k = 3; k >= 0; k--) exp_q.push_back(ew(-2048, 2047, k));
    t_req = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      chk("trunc_pulse", 32'(trunc), 32'(j == 16));
      if (j == 27) chk("guard_grant_held", 32'({busy, t_grant}), 32'd3);
      if (j == 28) begin
        chk("trunc_cycles", 32'(busy_cnt), 32'd28);
        chk("guard_released", 32'({busy, t_grant}), 32'd0);
        busy_cnt = 0;
      end
    end
    chk("regrant", 32'(t_grant), 32'd1);
    t_req = 1'b0;
    exp_q.push_back(ew(-2048, 2047, 0));
    wait_idle("trunc_idle");
    chk("short_burst_cycles", 32'(busy_cnt), 32'd9);
    chk("trunc_count", 32'(tr_cnt), 32'd1);
    chk("trunc_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of ACTIVE.
    mon_en = 1'b0;
    t_i = 12'd300; t_q = 12'(-300);
    t_req = 1'b1;
    repeat (8) @(negedge clk);
    chk("pre_reset_dac_on", 32'(dac_on), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dac", 32'({dac_i, dac_q}), 32'h800800);
    chk("rst_flags", 32'({dac_on, busy, m_grant, t_grant, m_ready, underrun, trunc}), 32'd0);
    t_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'({busy, dac_on, dac_i, dac_q}), 32'h0800800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
